// File: rtl/split_controller.sv
// Split transaction tracker: masks owners of outstanding splits and schedules their resume.
// Optional per-entry expiry is compiled in when SPLIT_TIMEOUT_EN is defined.
module split_controller #(
   parameter int NUM_MASTERS    = 2,
   parameter int NUM_SLAVES     = 3,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int M_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
   localparam int S_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   split_i,
   input  logic [S_W-1:0]         split_slave_i,
   input  logic [M_W-1:0]         cur_master_i,
   input  logic [NUM_SLAVES-1:0]  slave_ready_i,
   input  logic                   frame_active_i,
   input  logic                   resume_ack_i,
   output logic [NUM_MASTERS-1:0] master_mask_o,
   output logic                   resume_valid_o,
   output logic [M_W-1:0]         resume_master_o,
   output logic [S_W-1:0]         resume_slave_o,
   output logic                   split_pending_o,
   output logic                   timeout_o,
   output logic                   err_o,
   output logic [1:0]             state_o
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_START, WAIT_END} state_t;

   state_t                state_q, state_d;
   logic [S_W-1:0]        sel_q, sel_d;
   logic [NUM_SLAVES-1:0] valid_q;
   logic [M_W-1:0]        owner_q [NUM_SLAVES];
   logic                  err_q, timeout_q;
   logic [NUM_SLAVES-1:0] expire;
   logic [NUM_SLAVES-1:0] cand;
   logic                  slave_ok, slot_busy, rearm, split_err, capture, retire;

   always_comb begin
      master_mask_o = '0;
      for (int s = 0; s < NUM_SLAVES; s++)
         if (valid_q[s]) master_mask_o[owner_q[s]] = 1'b1;
   end

   assign split_pending_o = |valid_q;
   assign err_o           = err_q;
   assign timeout_o       = timeout_q;
   assign state_o         = state_q;

   always_comb begin
      slot_busy = 1'b0;
      for (int s = 0; s < NUM_SLAVES; s++)
         if (split_slave_i == S_W'(s)) slot_busy = valid_q[s];
   end

   // A resumed frame that splits again keeps its entry instead of raising an error.
   assign slave_ok  = int'(split_slave_i) < NUM_SLAVES;
   assign rearm     = split_i && (state_q == WAIT_END) && (split_slave_i == sel_q) &&
                      (cur_master_i == owner_q[sel_q]);
   assign split_err = split_i && !rearm && (!slave_ok || slot_busy || master_mask_o[cur_master_i]);
   assign capture   = split_i && !rearm && !split_err;
   assign cand      = valid_q & slave_ready_i & ~expire;

   // Handshake: resume_valid_o stays high with stable master/slave until resume_ack_i,
   // and is withdrawn only when the selected slave drops its ready level.
   always_comb begin
      state_d         = state_q;
      sel_d           = sel_q;
      retire          = 1'b0;
      resume_valid_o  = 1'b0;
      resume_master_o = '0;
      resume_slave_o  = '0;
      case (state_q)
         IDLE: begin
            for (int s = NUM_SLAVES - 1; s >= 0; s--)
               if (cand[s]) sel_d = S_W'(s);
            if (|cand) state_d = REQ;
         end
         REQ: begin
            resume_valid_o  = 1'b1;
            resume_master_o = owner_q[sel_q];
            resume_slave_o  = sel_q;
            if (resume_ack_i)                state_d = WAIT_START;
            else if (!slave_ready_i[sel_q])  state_d = IDLE;
         end
         WAIT_START: if (frame_active_i) state_d = WAIT_END;
         WAIT_END: begin
            if (rearm) begin
               state_d = IDLE;
            end else if (!frame_active_i) begin
               retire  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q   <= '0;
         err_q     <= 1'b0;
         timeout_q <= 1'b0;
         for (int s = 0; s < NUM_SLAVES; s++) owner_q[s] <= '0;
      end else begin
         err_q     <= split_err;
         timeout_q <= |expire;
         for (int s = 0; s < NUM_SLAVES; s++) begin
            if (expire[s] || (retire && sel_q == S_W'(s))) valid_q[s] <= 1'b0;
            if (capture && split_slave_i == S_W'(s)) begin
               valid_q[s] <= 1'b1;
               owner_q[s] <= cur_master_i;
            end
         end
      end
   end

`ifdef SPLIT_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

   logic [CNT_W-1:0]      cnt_q [NUM_SLAVES];
   logic [NUM_SLAVES-1:0] aging;

   // The entry currently being resumed is exempt from ageing.
   always_comb begin
      for (int s = 0; s < NUM_SLAVES; s++) begin
         aging[s]  = valid_q[s] && !((state_q != IDLE) && (sel_q == S_W'(s)));
         expire[s] = aging[s] && (cnt_q[s] == CNT_W'(TIMEOUT_CYCLES - 1));
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int s = 0; s < NUM_SLAVES; s++) cnt_q[s] <= '0;
      end else begin
         for (int s = 0; s < NUM_SLAVES; s++) begin
            if (!valid_q[s] || expire[s] || (capture && split_slave_i == S_W'(s)) ||
                (rearm && sel_q == S_W'(s)))
               cnt_q[s] <= '0;
            else if (aging[s])
               cnt_q[s] <= cnt_q[s] + 1'b1;
         end
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign expire         = '0;
`endif

endmodule
